// File: rtl/axi_r_return_router.sv
// -----------------------------------------------------------------------------
// axi_r_return_router
//
// Response-side half of the shared AXI read path. Every accepted AR request
// pushes the index of the winning master into an in-order FIFO. R beats from
// the shared slave port are routed to the master at the FIFO head, one burst
// at a time. The head is popped when RLAST is handshaken.
//
// Parameters:
//   MASTER_NUM  number of masters (matches the AR arbiter request width)
//   DATA_WIDTH  RDATA width
//   DEPTH       maximum outstanding bursts (power of two, >= 2)
//
// Ports:
//   ACLK, ARESET     clock, asynchronous active-high reset
//   ar_gnt, ar_fire  AR grant vector and slave-side AR handshake (push)
//   ar_stall         FIFO full; the interconnect gates slave ARVALID with it
//   s_r*             slave-side R channel (s_rready is an output)
//   m_r*             master-side R channel; data/resp/last are broadcast,
//                    m_rvalid / m_rready are per master
//   outstanding      number of bursts currently recorded in the FIFO
//   err              sticky protocol-error flag (only with R_ROUTER_ERR_EN)
//
// Configuration macro: R_ROUTER_ERR_EN adds the err output and its logic.
// -----------------------------------------------------------------------------
module axi_r_return_router #(
  parameter int MASTER_NUM = 2,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                         ACLK,
  input  logic                         ARESET,
  input  logic [MASTER_NUM-1:0]        ar_gnt,
  input  logic                         ar_fire,
  output logic                         ar_stall,
  input  logic [DATA_WIDTH-1:0]        s_rdata,
  input  logic [1:0]                   s_rresp,
  input  logic                         s_rlast,
  input  logic                         s_rvalid,
  output logic                         s_rready,
  output logic [DATA_WIDTH-1:0]        m_rdata,
  output logic [1:0]                   m_rresp,
  output logic                         m_rlast,
  output logic [MASTER_NUM-1:0]        m_rvalid,
  input  logic [MASTER_NUM-1:0]        m_rready,
  output logic [$clog2(DEPTH+1)-1:0]   outstanding
`ifdef R_ROUTER_ERR_EN
  ,
  output logic                         err
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (MASTER_NUM > 1) ? $clog2(MASTER_NUM) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [IDX_W-1:0] fifo_q [DEPTH];
  logic [IDX_W-1:0] fifo_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             empty;
  logic             full;
  logic             push;
  logic             pop;
  logic [IDX_W-1:0] push_idx;
  logic [IDX_W-1:0] head_idx;

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == FULL_CNT);
  assign head_idx = fifo_q[rd_ptr_q];

  // Highest set grant bit wins, mirroring the fixed-priority arbiter.
  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    push_idx = '0;
    for (int i = 0; i < MASTER_NUM; i++) begin
      if (ar_gnt[i]) push_idx = IDX_W'(i);
    end
  end

  // A push while full is dropped; there is no same-cycle pop bypass.
  assign push = ar_fire & (|ar_gnt) & ~full;

  // Routing: only the head master sees RVALID, and only its RREADY matters.
  // Comparing against each index keeps out-of-range head values harmless.
  always_comb begin
    m_rvalid = '0;
    s_rready = 1'b0;
    for (int i = 0; i < MASTER_NUM; i++) begin
      if (head_idx == IDX_W'(i)) begin
        m_rvalid[i] = s_rvalid & ~empty;
        s_rready    = m_rready[i] & ~empty;
      end
    end
  end

  assign pop = s_rvalid & s_rready & s_rlast;

  assign m_rdata = s_rdata;
  assign m_rresp = s_rresp;
  assign m_rlast = s_rlast;

  assign ar_stall    = full;
  assign outstanding = cnt_q;

  // Next-state for pointers, count and FIFO storage.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    fifo_d   = fifo_q;
    if (push) begin
      fifo_d[wr_ptr_q] = push_idx;
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // its _d value from before the edge, independent of statement order.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; an entry is only read
  // when the count says it was written, so clearing it would buy nothing.
  always_ff @(posedge ACLK) begin
    fifo_q <= fifo_d;
  end

`ifdef R_ROUTER_ERR_EN
  logic err_q, err_d;
  logic gnt_onehot;

  assign gnt_onehot = (ar_gnt != '0) && ((ar_gnt & (ar_gnt - 1'b1)) == '0);

  // Sticky: R beat with nothing outstanding, malformed grant, push into full.
  always_comb begin
    err_d = err_q;
    if ((s_rvalid & empty) | (ar_fire & ~gnt_onehot) | (ar_fire & full)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_axi_r_return_router.sv
// -----------------------------------------------------------------------------
// Testbench for axi_r_return_router (MASTER_NUM=2, DATA_WIDTH=32, DEPTH=4).
// A queue of master indices is the reference model of the return order.
// Inputs change 1 time unit after a rising edge; outputs are sampled a few
// units later, well before the next rising edge.
// -----------------------------------------------------------------------------
module tb_axi_r_return_router;

  localparam int MN = 2;
  localparam int DW = 32;
  localparam int DP = 4;
  localparam int CW = $clog2(DP + 1);

  logic          ACLK;
  logic          ARESET;
  logic [MN-1:0] ar_gnt;
  logic          ar_fire;
  logic          ar_stall;
  logic [DW-1:0] s_rdata;
  logic [1:0]    s_rresp;
  logic          s_rlast;
  logic          s_rvalid;
  logic          s_rready;
  logic [DW-1:0] m_rdata;
  logic [1:0]    m_rresp;
  logic          m_rlast;
  logic [MN-1:0] m_rvalid;
  logic [MN-1:0] m_rready;
  logic [CW-1:0] outstanding;
`ifdef R_ROUTER_ERR_EN
  logic          err;
`endif

  int n_cmp = 0;
  int n_mis = 0;
  int model_q[$];

  axi_r_return_router #(
    .MASTER_NUM(MN),
    .DATA_WIDTH(DW),
    .DEPTH     (DP)
  ) dut (
    .ACLK       (ACLK),
    .ARESET     (ARESET),
    .ar_gnt     (ar_gnt),
    .ar_fire    (ar_fire),
    .ar_stall   (ar_stall),
    .s_rdata    (s_rdata),
    .s_rresp    (s_rresp),
    .s_rlast    (s_rlast),
    .s_rvalid   (s_rvalid),
    .s_rready   (s_rready),
    .m_rdata    (m_rdata),
    .m_rresp    (m_rresp),
    .m_rlast    (m_rlast),
    .m_rvalid   (m_rvalid),
    .m_rready   (m_rready),
    .outstanding(outstanding)
`ifdef R_ROUTER_ERR_EN
    ,
    .err        (err)
`endif
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // ---------------- reference model ----------------
  function automatic int hi_idx(input logic [MN-1:0] g);
    int r = 0;
    for (int i = 0; i < MN; i++) if (g[i]) r = i;
    return r;
  endfunction

  function automatic logic [MN-1:0] exp_mrvalid();
    logic [MN-1:0] r = '0;
    if (model_q.size() != 0 && s_rvalid) r[model_q[0]] = 1'b1;
    return r;
  endfunction

  function automatic logic exp_srready();
    if (model_q.size() == 0) return 1'b0;
    return m_rready[model_q[0]];
  endfunction

  // Advance one clock edge and apply the model's push/pop rules.
  task automatic tick();
    bit do_push, do_pop;
    int idx;
    do_push = ar_fire && (ar_gnt != '0) && (model_q.size() < DP);
    do_pop  = (model_q.size() != 0) && s_rvalid && s_rlast && m_rready[model_q[0]];
    idx     = hi_idx(ar_gnt);
    @(posedge ACLK);
    if (!ARESET) begin
      if (do_pop)  void'(model_q.pop_front());
      if (do_push) model_q.push_back(idx);
    end
    #1;
  endtask

  task automatic idle_inputs();
    ar_fire  = 1'b0;
    ar_gnt   = '0;
    s_rvalid = 1'b0;
    s_rlast  = 1'b0;
    m_rready = '0;
    s_rdata  = '0;
    s_rresp  = 2'b00;
  endtask

  task automatic do_reset();
    idle_inputs();
    ARESET = 1'b1;
    model_q.delete();
    @(posedge ACLK);
    #1;
    ARESET = 1'b0;
  endtask

  task automatic push_one(input logic [MN-1:0] g);
    ar_fire = 1'b1;
    ar_gnt  = g;
    tick();
    ar_fire = 1'b0;
    ar_gnt  = '0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    push_one(2'b01);
    push_one(2'b10);
    s_rvalid = 1'b1;
    s_rlast  = 1'b0;
    m_rready = 2'b11;
    s_rdata  = 32'hCAFE_0001;
    s_rresp  = 2'b10;
    s_rlast  = 1'b1;
    #2;
    n_cmp++;
    if (outstanding !== CW'(2)) begin
      n_mis++;
      $display("FAIL reset_pre_outstanding: got %0d want 2", outstanding);
    end
    // Asynchronous reset away from any clock edge.
    ARESET = 1'b1;
    model_q.delete();
    #1;
    n_cmp++;
    if (outstanding !== '0) begin
      n_mis++;
      $display("FAIL reset_outstanding: got %0d want 0", outstanding);
    end
    n_cmp++;
    if (ar_stall !== 1'b0) begin
      n_mis++;
      $display("FAIL reset_ar_stall: got %b want 0", ar_stall);
    end
    n_cmp++;
    if (s_rready !== 1'b0) begin
      n_mis++;
      $display("FAIL reset_s_rready: got %b want 0", s_rready);
    end
    n_cmp++;
    if (m_rvalid !== 2'b00) begin
      n_mis++;
      $display("FAIL reset_m_rvalid: got %b want 00", m_rvalid);
    end
    n_cmp++;
    if ({m_rdata, m_rresp, m_rlast} !== {32'hCAFE_0001, 2'b10, 1'b1}) begin
      n_mis++;
      $display("FAIL reset_passthru: got %h/%b/%b want cafe0001/10/1",
               m_rdata, m_rresp, m_rlast);
    end
    @(posedge ACLK);
    #1;
    ARESET = 1'b0;
    #2;
    n_cmp++;
    if (s_rready !== 1'b0 || m_rvalid !== 2'b00) begin
      n_mis++;
      $display("FAIL reset_after_stall: got s_rready=%b m_rvalid=%b want 0/00",
               s_rready, m_rvalid);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_ordered_return();
    do_reset();
    push_one(2'b10);
    push_one(2'b01);
    #2;
    n_cmp++;
    if (outstanding !== CW'(2)) begin
      n_mis++;
      $display("FAIL order_outstanding2: got %0d want 2", outstanding);
    end
    m_rready = 2'b11;
    s_rvalid = 1'b1;
    for (int b = 0; b < 3; b++) begin
      s_rlast = (b == 2);
      s_rdata = DW'(32'h100 + b);
      #2;
      n_cmp++;
      if (m_rvalid !== 2'b10 || s_rready !== 1'b1) begin
        n_mis++;
        $display("FAIL order_burst0_beat%0d: got m_rvalid=%b s_rready=%b want 10/1",
                 b, m_rvalid, s_rready);
      end
      tick();
    end
    n_cmp++;
    if (outstanding !== CW'(1)) begin
      n_mis++;
      $display("FAIL order_outstanding1: got %0d want 1", outstanding);
    end
    s_rlast = 1'b1;
    #2;
    n_cmp++;
    if (m_rvalid !== 2'b01 || s_rready !== 1'b1) begin
      n_mis++;
      $display("FAIL order_burst1: got m_rvalid=%b s_rready=%b want 01/1",
               m_rvalid, s_rready);
    end
    tick();
    s_rvalid = 1'b0;
    #2;
    n_cmp++;
    if (outstanding !== CW'(0)) begin
      n_mis++;
      $display("FAIL order_outstanding0: got %0d want 0", outstanding);
    end
    idle_inputs();
  endtask

  task automatic test_full();
    logic [MN-1:0] drain_exp [4];
    drain_exp = '{2'b10, 2'b01, 2'b01, 2'b10};
    do_reset();
    push_one(2'b01);
    push_one(2'b10);
    push_one(2'b10);
    push_one(2'b01);
    #2;
    n_cmp++;
    if (ar_stall !== 1'b1 || outstanding !== CW'(4)) begin
      n_mis++;
      $display("FAIL full_four: got ar_stall=%b outstanding=%0d want 1/4",
               ar_stall, outstanding);
    end
    push_one(2'b10);  // dropped
    #2;
    n_cmp++;
    if (outstanding !== CW'(4)) begin
      n_mis++;
      $display("FAIL full_fifth_dropped: got %0d want 4", outstanding);
    end
    // Pop of head (master 0) while full: stall does not drop in the same cycle.
    s_rvalid = 1'b1;
    s_rlast  = 1'b1;
    m_rready = 2'b11;
    #2;
    n_cmp++;
    if (ar_stall !== 1'b1 || s_rready !== 1'b1) begin
      n_mis++;
      $display("FAIL full_pop_stall: got ar_stall=%b s_rready=%b want 1/1",
               ar_stall, s_rready);
    end
    tick();
    // Pop plus push in the same cycle leaves the count unchanged.
    ar_fire = 1'b1;
    ar_gnt  = 2'b01;
    tick();
    ar_fire  = 1'b0;
    s_rvalid = 1'b0;
    #2;
    n_cmp++;
    if (outstanding !== CW'(3) || ar_stall !== 1'b0) begin
      n_mis++;
      $display("FAIL full_pop_push: got outstanding=%0d ar_stall=%b want 3/0",
               outstanding, ar_stall);
    end
    push_one(2'b10);
    #2;
    n_cmp++;
    if (outstanding !== CW'(4) || ar_stall !== 1'b1) begin
      n_mis++;
      $display("FAIL full_refill: got outstanding=%0d ar_stall=%b want 4/1",
               outstanding, ar_stall);
    end
    // Drain single-beat bursts and check the recorded order.
    s_rvalid = 1'b1;
    s_rlast  = 1'b1;
    m_rready = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #2;
      n_cmp++;
      if (m_rvalid !== drain_exp[k]) begin
        n_mis++;
        $display("FAIL full_drain%0d: got %b want %b", k, m_rvalid, drain_exp[k]);
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_backpressure();
    do_reset();
    push_one(2'b10);
    s_rvalid = 1'b1;
    s_rlast  = 1'b1;
    m_rready = 2'b01;
    for (int c = 0; c < 3; c++) begin
      #2;
      n_cmp++;
      if (s_rready !== 1'b0 || m_rvalid !== 2'b10 || outstanding !== CW'(1)) begin
        n_mis++;
        $display("FAIL bp_hold%0d: got s_rready=%b m_rvalid=%b outstanding=%0d want 0/10/1",
                 c, s_rready, m_rvalid, outstanding);
      end
      tick();
    end
    m_rready = 2'b10;
    #2;
    n_cmp++;
    if (s_rready !== 1'b1) begin
      n_mis++;
      $display("FAIL bp_release: got s_rready=%b want 1", s_rready);
    end
    tick();
    s_rvalid = 1'b0;
    #2;
    n_cmp++;
    if (outstanding !== CW'(0)) begin
      n_mis++;
      $display("FAIL bp_popped: got %0d want 0", outstanding);
    end
    idle_inputs();
  endtask

  task automatic test_empty_same_cycle();
    do_reset();
    s_rvalid = 1'b1;
    s_rlast  = 1'b1;
    m_rready = 2'b11;
    ar_fire  = 1'b1;
    ar_gnt   = 2'b01;
    #2;
    n_cmp++;
    if (s_rready !== 1'b0 || m_rvalid !== 2'b00) begin
      n_mis++;
      $display("FAIL empty_no_bypass: got s_rready=%b m_rvalid=%b want 0/00",
               s_rready, m_rvalid);
    end
    tick();
    ar_fire = 1'b0;
    ar_gnt  = '0;
    #2;
    n_cmp++;
    if (s_rready !== 1'b1 || m_rvalid !== 2'b01) begin
      n_mis++;
      $display("FAIL empty_next_cycle: got s_rready=%b m_rvalid=%b want 1/01",
               s_rready, m_rvalid);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      ar_fire  = 1'($urandom_range(0, 1));
      ar_gnt   = MN'($urandom_range(0, 3));
      s_rvalid = ($urandom_range(0, 3) != 0);
      s_rlast  = ($urandom_range(0, 2) == 0);
      m_rready = MN'($urandom_range(0, 3));
      s_rdata  = $urandom;
      s_rresp  = 2'($urandom_range(0, 3));
      #2;
      n_cmp++;
      if (m_rvalid !== exp_mrvalid()) begin
        n_mis++;
        $display("FAIL rand_m_rvalid@%0d: got %b want %b", c, m_rvalid, exp_mrvalid());
      end
      n_cmp++;
      if (s_rready !== exp_srready()) begin
        n_mis++;
        $display("FAIL rand_s_rready@%0d: got %b want %b", c, s_rready, exp_srready());
      end
      n_cmp++;
      if (outstanding !== CW'(model_q.size()) ||
          ar_stall !== (model_q.size() == DP)) begin
        n_mis++;
        $display("FAIL rand_count@%0d: got outstanding=%0d ar_stall=%b want %0d/%b",
                 c, outstanding, ar_stall, model_q.size(), model_q.size() == DP);
      end
      n_cmp++;
      if ({m_rdata, m_rresp, m_rlast} !== {s_rdata, s_rresp, s_rlast}) begin
        n_mis++;
        $display("FAIL rand_passthru@%0d: got %h/%b/%b want %h/%b/%b",
                 c, m_rdata, m_rresp, m_rlast, s_rdata, s_rresp, s_rlast);
      end
      tick();
    end
    idle_inputs();
  endtask

`ifdef R_ROUTER_ERR_EN
  task automatic test_err();
    do_reset();
    #2;
    n_cmp++;
    if (err !== 1'b0) begin
      n_mis++;
      $display("FAIL err_clear: got %b want 0", err);
    end
    push_one(2'b11);
    #2;
    n_cmp++;
    if (err !== 1'b1 || outstanding !== CW'(1)) begin
      n_mis++;
      $display("FAIL err_set: got err=%b outstanding=%0d want 1/1", err, outstanding);
    end
    s_rvalid = 1'b1;
    s_rlast  = 1'b1;
    m_rready = 2'b11;
    #2;
    n_cmp++;
    if (m_rvalid !== 2'b10) begin
      n_mis++;
      $display("FAIL err_push_index: got %b want 10", m_rvalid);
    end
    tick();
    idle_inputs();
    for (int c = 0; c < 3; c++) tick();
    n_cmp++;
    if (err !== 1'b1) begin
      n_mis++;
      $display("FAIL err_sticky: got %b want 1", err);
    end
    ARESET = 1'b1;
    model_q.delete();
    #1;
    n_cmp++;
    if (err !== 1'b0) begin
      n_mis++;
      $display("FAIL err_reset: got %b want 0", err);
    end
    @(posedge ACLK);
    #1;
    ARESET = 1'b0;
  endtask
`endif

  initial begin
    ARESET = 1'b1;
    idle_inputs();
    test_reset();
    test_ordered_return();
    test_full();
    test_backpressure();
    test_empty_same_cycle();
    test_random();
`ifdef R_ROUTER_ERR_EN
    test_err();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
